rle_stream_writer: RTL and testbench
====================================

Name: rle_stream_writer

Overview:
Clocked, parametrised successor to the combinational decompress path. Accepts run-length tokens (bit value + run length) over a valid/ready handshake, packs the expanded bits MSB-first into DATA_W-bit words starting at an arbitrary byte/bit index, and writes each word to memory through a masked write handshake. Partial first and last words are written with a bit mask so neighbouring data is never clobbered. Reports the next free byte/bit index for chaining the next stream.

Parameters:
DATA_W, 8, memory word width in bits (power of two, ≥8)
ADDR_W, 16, word address width
RUN_W, 7, run-length field width
POS_W, $clog2(DATA_W), bit-position width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a stream; sampled only in IDLE
startByteIndx  in  ADDR_W  first word address
startBitIndx  in  POS_W  first bit position (0 = MSB)
tokValid  in  1  token available
tokReady  out  1  token accepted this cycle when tokValid is also high
tokBit  in  1  bit value of run
tokRun  in  RUN_W  run length in bits (0 = emits nothing)
tokLast  in  1  final token of stream
memWrite  out  1  write request
memAddr  out  ADDR_W  write address
memData  out  DATA_W  write data
memMask  out  DATA_W  per-bit write enable
memAck  in  1  write accepted
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
newByteIndx  out  ADDR_W  next free word address
newBitIndx  out  POS_W  next free bit position

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal word, mask, remaining-run count and position cleared; memWrite drops immediately, mid-transaction included.
- States: IDLE, FILL, WRITE, DONE.
- IDLE: on start, latch addr=startByteIndx, pos=startBitIndx, word=0, mask=0, rem=0, go FILL. start is ignored in any other state.
- FILL, rem==0: tokReady=1 (combinational). On tokValid: load rem=tokRun, bit=tokBit, last=tokLast. The load cycle emits no bits.
- FILL, rem>0: n=min(rem, DATA_W-pos); set word/mask at positions pos..pos+n-1 (position p maps to data bit DATA_W-1-p); pos+=n; rem-=n; one chunk per cycle.
- pos reaching DATA_W: go WRITE (full word).
- rem==0 with last latched:
  - mask≠0: go WRITE with flush flag.
  - mask==0: go DONE.
- WRITE: memWrite=1 with memAddr/memData/memMask stable until memAck is sampled high; tokReady=0.
  - On ack, non-flush: addr+=1 (wraps mod 2^ADDR_W), pos=0, word/mask cleared, back to FILL.
  - On ack, flush: addr and pos unchanged, go DONE.
- DONE: done=1 for one cycle; newByteIndx=addr, newBitIndx=pos (pos<DATA_W always); go IDLE. New indices hold until the next DONE.
- memAck outside WRITE is ignored. tokValid outside FILL/rem==0 is not accepted.
- A token carrying both tokRun=0 and tokLast is legal and ends the stream.

Optional Feature:
Macro RLE_STREAM_WRITER_BOUND_CHK_EN.
- Defined: adds input limitByteIndx[ADDR_W] (latched on start) and output error (sticky until next start or reset). A write whose addr > limit is not issued: error=1, go DONE with newByteIndx=addr, newBitIndx=0, and remaining tokens are not consumed.
- Undefined: neither port exists; addresses wrap freely.

Test Plan:
- DATA_W=8, start 0x10/0; tokens (1,3),(0,5,last); ack after 1 cycle → one write addr 0x10 data 0xE0 mask 0xFF; done; new 0x11/0.
- Start 0x20/5; token (1,6,last) → write 0x20 data 0x07 mask 0x07, then write 0x21 data 0xE0 mask 0xE0; new 0x21/3.
- Same as first scenario with memAck delayed 4 cycles → memWrite/addr/data/mask stable for 5 cycles, tokReady 0 throughout, a single write.
- Start 0x30/2; token (0,0,last) → no memWrite; done; new 0x30/2.
- rst_n pulled low while memWrite=1 → memWrite, busy, done, new indices all 0 immediately; after release, start accepted normally.
- BOUND_CHK_EN, limit 0x10, start 0x10/4, token (1,12,last) → write 0x10 data 0x0F mask 0x0F; second write blocked; error=1; new 0x11/0.

Source files
------------

// File: rtl/rle_stream_writer_if.sv
// ============================================================================
// rle_stream_writer_if
// ----------------------------------------------------------------------------
// Purpose : Groups the two handshakes of rle_stream_writer into one bundle.
//           - token stream : tokValid/tokReady carrying tokBit/tokRun/tokLast
//           - memory write : memWrite/memAck carrying memAddr/memData/memMask
//
// Modports:
//   slave  - the writer: consumes tokens, issues memory writes
//   master - the environment: produces tokens, accepts memory writes
// ============================================================================
interface rle_stream_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int RUN_W  = 7
) ();
    // token stream
    logic              tokValid;
    logic              tokReady;
    logic              tokBit;
    logic [RUN_W-1:0]  tokRun;
    logic              tokLast;

    // masked memory write
    logic              memWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] memMask;
    logic              memAck;

    modport slave (
        input  tokValid, tokBit, tokRun, tokLast,
        output tokReady,
        output memWrite, memAddr, memData, memMask,
        input  memAck
    );

    modport master (
        output tokValid, tokBit, tokRun, tokLast,
        input  tokReady,
        input  memWrite, memAddr, memData, memMask,
        output memAck
    );
endinterface

// File: rtl/rle_stream_writer.sv
// ============================================================================
// rle_stream_writer
// ----------------------------------------------------------------------------
// Purpose : Expands run-length tokens (bit value + run length) into a bit
//           stream, packs it MSB-first into DATA_W-bit words starting at an
//           arbitrary word address / bit position, and writes each word out
//           with a per-bit mask so partial first/last words never disturb
//           neighbouring data. Reports the next free address/bit position
//           so a following stream can be chained on.
//
// Optional feature (macro RLE_STREAM_WRITER_BOUND_CHK_EN):
//           adds input limitByteIndx and sticky output error. Any write whose
//           address exceeds the limit is suppressed and the stream ends.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a stream (sampled only while idle)
//   startByteIndx  in   first word address
//   startBitIndx   in   first bit position (0 = MSB)
//   bus            --   token stream + memory write handshakes (slave side)
//   busy           out  high while a stream is in progress
//   done           out  one-cycle completion pulse
//   newByteIndx    out  next free word address (valid from the done pulse)
//   newBitIndx     out  next free bit position
//   limitByteIndx  in   highest writable address   (bound check only)
//   error          out  sticky bound violation flag (bound check only)
// ============================================================================
module rle_stream_writer #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 16,
    parameter  int RUN_W  = 7,
    localparam int POS_W  = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  startByteIndx,
    input  logic [POS_W-1:0]   startBitIndx,
    rle_stream_writer_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  newByteIndx,
    output logic [POS_W-1:0]   newBitIndx
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
    ,
    input  logic [ADDR_W-1:0]  limitByteIndx,
    output logic               error
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Arithmetic width wide enough for both a run length and DATA_W itself.
    localparam int CW = (RUN_W > POS_W + 1) ? RUN_W : POS_W + 1;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [POS_W:0]     pos_q;        // one extra bit so DATA_W is representable
    logic [DATA_W-1:0]  word_q;
    logic [DATA_W-1:0]  mask_q;
    logic [RUN_W-1:0]   rem_q;
    logic               bit_q;
    logic               last_q;
    logic               flush_q;      // current write is the final partial word
    logic               mem_write_q;
    logic               done_q;
    logic [ADDR_W-1:0]  new_byte_q;
    logic [POS_W-1:0]   new_bit_q;
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
    logic [ADDR_W-1:0]  limit_q;
    logic               error_q;
`endif

    // ------------------------------------------------------------------
    // Chunk computation: n = min(rem, DATA_W - pos) bits land at
    // positions pos .. pos+n-1 of the current word.
    // ------------------------------------------------------------------
    logic [CW-1:0]      rem_ext;
    logic [CW-1:0]      pos_ext;
    logic [CW-1:0]      room;
    logic [CW-1:0]      take;
    logic [CW-1:0]      pos_end;
    logic [DATA_W-1:0]  chunk_mask;
    logic [DATA_W-1:0]  word_fill;
    logic [DATA_W-1:0]  mask_fill;
    logic [POS_W:0]     pos_next;
    logic [RUN_W-1:0]   rem_next;
    logic               word_full;
    logic               over_limit;

    assign rem_ext = CW'(rem_q);
    assign pos_ext = CW'(pos_q);
    assign room    = CW'(DATA_W) - pos_ext;
    assign take    = (rem_ext < room) ? rem_ext : room;
    assign pos_end = pos_ext + take;

    // Bit position p corresponds to data bit DATA_W-1-p (MSB-first packing).
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_chunk
            assign chunk_mask[DATA_W-1-gi] = (CW'(gi) >= pos_ext) && (CW'(gi) < pos_end);
        end
    endgenerate

    assign word_fill = (word_q & ~chunk_mask) | ({DATA_W{bit_q}} & chunk_mask);
    assign mask_fill = mask_q | chunk_mask;
    assign pos_next  = pos_end[POS_W:0];
    assign rem_next  = rem_q - take[RUN_W-1:0];
    assign word_full = (pos_end == CW'(DATA_W));

`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
    assign over_limit = (addr_q > limit_q);
    assign error      = error_q;
`else
    assign over_limit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // A token is only taken when the previous run is exhausted and the
    // stream has not already seen its last token.
    assign bus.tokReady = (state_q == FILL) && (rem_q == '0) && !last_q;
    assign bus.memWrite = mem_write_q;
    assign bus.memAddr  = addr_q;
    assign bus.memData  = word_q;
    assign bus.memMask  = mask_q;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign newByteIndx = new_byte_q;
    assign newBitIndx  = new_bit_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pos_q       <= '0;
            word_q      <= '0;
            mask_q      <= '0;
            rem_q       <= '0;
            bit_q       <= 1'b0;
            last_q      <= 1'b0;
            flush_q     <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            new_byte_q  <= '0;
            new_bit_q   <= '0;
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
            limit_q     <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= startByteIndx;
                        pos_q   <= {1'b0, startBitIndx};
                        word_q  <= '0;
                        mask_q  <= '0;
                        rem_q   <= '0;
                        last_q  <= 1'b0;
                        flush_q <= 1'b0;
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
                        limit_q <= limitByteIndx;
                        error_q <= 1'b0;
`endif
                        state_q <= FILL;
                    end
                end

                FILL: begin
                    if (rem_q != '0) begin
                        word_q <= word_fill;
                        mask_q <= mask_fill;
                        pos_q  <= pos_next;
                        rem_q  <= rem_next;
                        if (word_full) begin
                            if (over_limit) begin
                                // Suppressed write: stream ends at the start
                                // of the word that could not be written.
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
                                error_q <= 1'b1;
`endif
                                pos_q      <= '0;
                                new_byte_q <= addr_q;
                                new_bit_q  <= '0;
                                done_q     <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                flush_q     <= 1'b0;
                                mem_write_q <= 1'b1;
                                state_q     <= WRITE;
                            end
                        end
                    end else if (last_q) begin
                        if (mask_q != '0) begin
                            if (over_limit) begin
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
                                error_q <= 1'b1;
`endif
                                pos_q      <= '0;
                                new_byte_q <= addr_q;
                                new_bit_q  <= '0;
                                done_q     <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                flush_q     <= 1'b1;
                                mem_write_q <= 1'b1;
                                state_q     <= WRITE;
                            end
                        end else begin
                            // Nothing pending: the stream ends on a word edge
                            // (or emitted no bits at all).
                            new_byte_q <= addr_q;
                            new_bit_q  <= pos_q[POS_W-1:0];
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end else if (bus.tokValid) begin
                        // Load cycle only; bits are emitted from the next cycle.
                        rem_q  <= bus.tokRun;
                        bit_q  <= bus.tokBit;
                        last_q <= bus.tokLast;
                    end
                end

                WRITE: begin
                    if (bus.memAck) begin
                        mem_write_q <= 1'b0;
                        if (flush_q) begin
                            // Partial last word: the next stream continues
                            // inside this same word.
                            new_byte_q <= addr_q;
                            new_bit_q  <= pos_q[POS_W-1:0];
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            pos_q   <= '0;
                            word_q  <= '0;
                            mask_q  <= '0;
                            state_q <= FILL;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_stream_writer.sv
module tb_rle_stream_writer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int RUN_W  = 7;
    localparam int POS_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] startByteIndx = '0;
    logic [POS_W-1:0]  startBitIndx = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] newByteIndx;
    logic [POS_W-1:0]  newBitIndx;
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
    logic [ADDR_W-1:0] limitByteIndx = '1;
    logic              error;
`endif

    rle_stream_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RUN_W(RUN_W)) bus ();

    rle_stream_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RUN_W(RUN_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .startByteIndx (startByteIndx),
        .startBitIndx  (startBitIndx),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .newByteIndx   (newByteIndx),
        .newBitIndx    (newBitIndx)
`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
        ,
        .limitByteIndx (limitByteIndx),
        .error         (error)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int wr_base;

    // Accepted memory writes (request and ack both high at a rising edge).
    always @(posedge clk) begin
        if (rst_n && bus.memWrite && bus.memAck) n_wr <= n_wr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [POS_W-1:0] p);
        start         = 1'b1;
        startByteIndx = a;
        startBitIndx  = p;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        $display("start addr=0x%0h bit=%0d", a, p);
    endtask

    task automatic send_tok(input logic b, input int run, input logic last);
        int cnt;
        bus.tokValid = 1'b1;
        bus.tokBit   = b;
        bus.tokRun   = RUN_W'(run);
        bus.tokLast  = last;
        cnt = 0;
        while (bus.tokReady !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("tok_ready_timeout", (cnt < 100), 1);
        @(negedge clk);
        bus.tokValid = 1'b0;
        $display("token bit=%0d run=%0d last=%0d", b, run, last);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic [DATA_W-1:0] m, input int delay);
        int cnt;
        cnt = 0;
        while (bus.memWrite !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("write_timeout", (cnt < 100), 1);
        chk("wr_addr", bus.memAddr, a);
        chk("wr_data", bus.memData, d);
        chk("wr_mask", bus.memMask, m);
        chk("wr_tokready", bus.tokReady, 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("hold_write", bus.memWrite, 1);
            chk("hold_addr", bus.memAddr, a);
            chk("hold_data", bus.memData, d);
            chk("hold_mask", bus.memMask, m);
            chk("hold_tokready", bus.tokReady, 0);
        end
        bus.memAck = 1'b1;
        @(negedge clk);
        bus.memAck = 1'b0;
        chk("write_dropped", bus.memWrite, 0);
        $display("write addr=0x%0h data=0x%0h mask=0x%0h ackdelay=%0d", a, d, m, delay);
    endtask

    task automatic expect_done(input logic [ADDR_W-1:0] a, input logic [POS_W-1:0] p);
        int cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("done_timeout", (cnt < 100), 1);
        chk("new_byte", newByteIndx, a);
        chk("new_bit", newBitIndx, p);
        @(negedge clk);
        chk("done_pulse_len", done, 0);
        chk("busy_idle", busy, 0);
        chk("new_byte_hold", newByteIndx, a);
        $display("done new addr=0x%0h bit=%0d", newByteIndx, newBitIndx);
    endtask

    initial begin
        bus.tokValid = 1'b0;
        bus.tokBit   = 1'b0;
        bus.tokRun   = '0;
        bus.tokLast  = 1'b0;
        bus.memAck   = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_memwrite", bus.memWrite, 0);
        chk("rst_tokready", bus.tokReady, 0);
        chk("rst_newbyte", newByteIndx, 0);
        chk("rst_newbit", newBitIndx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two tokens filling exactly one word
        do_start(16'h0010, 3'd0);
        wr_base = n_wr;
        send_tok(1'b1, 3, 1'b0);
        send_tok(1'b0, 5, 1'b1);
        expect_write(16'h0010, 8'hE0, 8'hFF, 0);
        expect_done(16'h0011, 3'd0);
        chk("s1_writes", n_wr - wr_base, 1);

        // 2: unaligned start spanning two words, partial last word
        do_start(16'h0020, 3'd5);
        wr_base = n_wr;
        send_tok(1'b1, 6, 1'b1);
        expect_write(16'h0020, 8'h07, 8'h07, 0);
        expect_write(16'h0021, 8'hE0, 8'hE0, 0);
        expect_done(16'h0021, 3'd3);
        chk("s2_writes", n_wr - wr_base, 2);

        // 3: scenario 1 with a slow acknowledge
        do_start(16'h0010, 3'd0);
        wr_base = n_wr;
        send_tok(1'b1, 3, 1'b0);
        send_tok(1'b0, 5, 1'b1);
        expect_write(16'h0010, 8'hE0, 8'hFF, 4);
        expect_done(16'h0011, 3'd0);
        chk("s3_writes", n_wr - wr_base, 1);

        // 4: empty last token, nothing written
        do_start(16'h0030, 3'd2);
        wr_base = n_wr;
        send_tok(1'b0, 0, 1'b1);
        expect_done(16'h0030, 3'd2);
        chk("s4_writes", n_wr - wr_base, 0);

        // 5: asynchronous reset in the middle of a write request
        do_start(16'h0040, 3'd0);
        send_tok(1'b1, 8, 1'b1);
        begin
            int cnt;
            cnt = 0;
            while (bus.memWrite !== 1'b1 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            chk("s5_write_timeout", (cnt < 100), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_memwrite", bus.memWrite, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_newbyte", newByteIndx, 0);
        chk("arst_newbit", newBitIndx, 0);
        $display("async reset during write");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(16'h0050, 3'd0);
        wr_base = n_wr;
        send_tok(1'b0, 8, 1'b1);
        expect_write(16'h0050, 8'h00, 8'hFF, 0);
        expect_done(16'h0051, 3'd0);
        chk("s5_writes", n_wr - wr_base, 1);

`ifdef RLE_STREAM_WRITER_BOUND_CHK_EN
        chk("no_error", error, 0);
        // 6: second word lies beyond the limit
        limitByteIndx = 16'h0010;
        do_start(16'h0010, 3'd4);
        wr_base = n_wr;
        send_tok(1'b1, 12, 1'b1);
        expect_write(16'h0010, 8'h0F, 8'h0F, 0);
        expect_done(16'h0011, 3'd0);
        chk("bound_error", error, 1);
        chk("s6_writes", n_wr - wr_base, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
